// File: rtl/seg7_pkg.sv
// Shared constants and the captured-word type for the seven-segment capture block.
// Optional fault-marker decoding is enabled with SEG7_FAULT_CODE_EN.
package seg7_pkg;

  // Active-low segment patterns, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_FAULT = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIB_FAULT = 4'hE;
  localparam logic [3:0] NIB_ERR   = 4'hF;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        fault;
  } word_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern into a BCD nibble.
// With SEG7_FAULT_CODE_EN the fault marker decodes to 4'hE and raises is_fault.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err,
  output logic       is_fault
);

  always_comb begin
    nibble   = NIB_ERR;
    err      = 1'b1;
    is_fault = 1'b0;
    case (pattern)
      SEG_0: begin nibble = 4'd0; err = 1'b0; end
      SEG_1: begin nibble = 4'd1; err = 1'b0; end
      SEG_2: begin nibble = 4'd2; err = 1'b0; end
      SEG_3: begin nibble = 4'd3; err = 1'b0; end
      SEG_4: begin nibble = 4'd4; err = 1'b0; end
      SEG_5: begin nibble = 4'd5; err = 1'b0; end
      SEG_6: begin nibble = 4'd6; err = 1'b0; end
      SEG_7: begin nibble = 4'd7; err = 1'b0; end
      SEG_8: begin nibble = 4'd8; err = 1'b0; end
      SEG_9: begin nibble = 4'd9; err = 1'b0; end
`ifdef SEG7_FAULT_CODE_EN
      // The marker is still flagged as not-a-digit, but distinguishable
      SEG_FAULT: begin nibble = NIB_FAULT; is_fault = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Debounces four seven-segment digit buses and hands settled, changed words over valid/ready.
// SEG7_FAULT_CODE_EN enables the fault-marker pattern (decoded in seg7_digit_decode).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg0,
  input  logic [6:0]  seg1,
  input  logic [6:0]  seg2,
  input  logic [6:0]  seg3,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] bcd,
  output logic [3:0]  digit_err,
  output logic        fault
);

  localparam logic [7:0] SETTLE = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_in [4];
  logic [6:0] samp   [4];
  logic [7:0] cnt    [4];
  logic [3:0] nib    [4];
  logic [3:0] err;
  logic [3:0] is_fault;
  logic [3:0] settled;
  word_t      dec_word;
  word_t      cur_word;
  word_t      last_word;
  logic       have_last;

  assign seg_in[0] = seg0;
  assign seg_in[1] = seg1;
  assign seg_in[2] = seg2;
  assign seg_in[3] = seg3;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    seg7_digit_decode u_dec (
      .pattern  (samp[i]),
      .nibble   (nib[i]),
      .err      (err[i]),
      .is_fault (is_fault[i])
    );
    assign settled[i] = (cnt[i] == SETTLE);
  end

  // Each digit counts consecutive matching samples independently of the others
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        samp[i] <= SEG_BLANK;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        samp[i] <= seg_in[i];
        if (seg_in[i] != samp[i])
          cnt[i] <= '0;
        else if (cnt[i] != SETTLE)
          cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  assign dec_word.bcd   = {nib[3], nib[2], nib[1], nib[0]};
  assign dec_word.err   = err;
  assign dec_word.fault = |is_fault;

  // Output word is frozen while pending; a repeat of the last delivered word is suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cur_word  <= '0;
      last_word <= '0;
      have_last <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      last_word <= cur_word;
      have_last <= 1'b1;
    end else if (!out_valid && (&settled) && (!have_last || dec_word != last_word)) begin
      out_valid <= 1'b1;
      cur_word  <= dec_word;
    end
  end

  assign bcd       = cur_word.bcd;
  assign digit_err = cur_word.err;
  assign fault     = cur_word.fault;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized traffic
// checked against a run-length reference model. Honors SEG7_FAULT_CODE_EN.
module tb_seg7_capture;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  seg [4];
  logic        out_valid;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        fault;

  int checks = 0;
  int passed = 0;

  logic [6:0] digit_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

  // Reference state: per digit, the latest sampled value and how many samples in a row it has held
  logic [6:0]  m_val [4];
  int          m_run [4];
  logic        m_valid;
  logic        m_have;
  logic [20:0] m_word;
  logic [20:0] m_last;

  seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg0      (seg[0]),
    .seg1      (seg[1]),
    .seg2      (seg[2]),
    .seg3      (seg[3]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bcd       (bcd),
    .digit_err (digit_err),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 10; d++)
      if (p == digit_pat[d]) return {2'b00, 4'(d)};
`ifdef SEG7_FAULT_CODE_EN
    if (p == 7'b1111110) return {2'b11, 4'hE};
`endif
    return {2'b01, 4'hF};
  endfunction

  function automatic logic [20:0] model_word();
    logic [15:0] b;
    logic [3:0]  e;
    logic        f;
    logic [5:0]  d;
    b = '0; e = '0; f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = ref_decode(m_val[i]);
      b[4*i +: 4] = d[3:0];
      e[i] = d[4];
      f = f | d[5];
    end
    return {b, e, f};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 7'b1111111;
      m_run[i] = 1;
    end
    m_valid = 1'b0;
    m_have  = 1'b0;
    m_word  = '0;
    m_last  = '0;
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples, then outputs settle
  task automatic tick();
    logic all_set;
    @(posedge clk);
    if (rst_n) begin
      all_set = 1'b1;
      for (int i = 0; i < 4; i++)
        if (m_run[i] < STABLE) all_set = 1'b0;
      if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_last  = m_word;
        m_have  = 1'b1;
      end else if (!m_valid && all_set && (!m_have || model_word() != m_last)) begin
        m_word  = model_word();
        m_valid = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (seg[i] == m_val[i]) m_run[i]++;
        else begin
          m_val[i] = seg[i];
          m_run[i] = 1;
        end
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input int d3, input int d2, input int d1, input int d0);
    seg[3] = digit_pat[d3];
    seg[2] = digit_pat[d2];
    seg[1] = digit_pat[d1];
    seg[0] = digit_pat[d0];
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 4; i++) seg[i] = 7'($urandom);
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, bcd, digit_err, fault} !== 22'h0) begin
      $display("[TB] FAIL reset_outputs: got %h expected %h", {out_valid, bcd, digit_err, fault}, 22'h0);
    end else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    applyStimulus(3, 0, 5, 9);
    out_ready = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL basic_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
      checks++;
      if (out_valid !== (t == 5)) begin
        $display("[TB] FAIL basic_pulse t=%0d: got %b expected %b", t, out_valid, (t == 5));
      end else passed++;
      if (t == 5) begin
        checks++;
        if ({bcd, digit_err} !== {16'h3059, 4'h0}) begin
          $display("[TB] FAIL basic_word: got %h expected %h", {bcd, digit_err}, {16'h3059, 4'h0});
        end else passed++;
      end
    end
  endtask

  task automatic test_flicker();
    int caps = 0;
    int cap_h = 0;
    logic [3:0] cap_nib = 4'h0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) seg[0] = ((c / 2) % 2 == 1) ? digit_pat[2] : digit_pat[1];
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL flicker_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
      checks++;
      if (out_valid !== 1'b0) begin
        $display("[TB] FAIL flicker_quiet c=%0d: got %b expected 0", c, out_valid);
      end else passed++;
    end
    for (int h = 1; h <= 10; h++) begin
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL flicker_hold_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
      if (out_valid) begin
        caps++;
        cap_h = h;
        cap_nib = bcd[3:0];
      end
    end
    // last change was two ticks before the hold loop, so tick 5 after it is h=3
    checks++;
    if ({caps, cap_h, 28'(cap_nib)} !== {32'd1, 32'd3, 28'd2}) begin
      $display("[TB] FAIL flicker_capture: got caps=%0d at=%0d nib=%h expected caps=1 at=3 nib=2", caps, cap_h, cap_nib);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [$];
    out_ready = 1'b0;
    applyStimulus(1, 2, 3, 4);
    for (int t = 0; t < 30; t++) begin
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL backpressure_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
    end
    applyStimulus(5, 6, 7, 8);
    repeat (10) tick();
    checks++;
    if ({out_valid, bcd} !== {1'b1, 16'h1234}) begin
      $display("[TB] FAIL backpressure_hold: got %h expected %h", {out_valid, bcd}, {1'b1, 16'h1234});
    end else passed++;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (out_valid) got.push_back(bcd);
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL backpressure_drain_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
    end
    checks++;
    if (got.size() != 2 || got[0] !== 16'h1234 || got[1] !== 16'h5678) begin
      $display("[TB] FAIL backpressure_order: got %0d words first=%h expected 2 words 1234 then 5678",
               got.size(), (got.size() > 0) ? got[0] : 16'h0);
    end else passed++;
  endtask

  task automatic test_fault();
    logic [20:0] exp_w;
`ifdef SEG7_FAULT_CODE_EN
    exp_w = {16'h0E00, 4'b0100, 1'b1};
`else
    exp_w = {16'h0F00, 4'b0100, 1'b0};
`endif
    out_ready = 1'b0;
    applyStimulus(0, 0, 0, 0);
    seg[2] = 7'b1111110;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL fault_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
    end
    checks++;
    if ({out_valid, bcd, digit_err, fault} !== {1'b1, exp_w}) begin
      $display("[TB] FAIL fault_word: got %h expected %h", {out_valid, bcd, digit_err, fault}, {1'b1, exp_w});
    end else passed++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    applyStimulus(4, 4, 4, 4);
    repeat (6) tick();
    checks++;
    if ({out_valid, bcd} !== {1'b1, 16'h4444}) begin
      $display("[TB] FAIL midreset_pending: got %h expected %h", {out_valid, bcd}, {1'b1, 16'h4444});
    end else passed++;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_valid, bcd, digit_err, fault} !== 22'h0) begin
      $display("[TB] FAIL midreset_clear: got %h expected %h", {out_valid, bcd, digit_err, fault}, 22'h0);
    end else passed++;
    #2;
    rst_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++;
      if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
        $display("[TB] FAIL midreset_model: got %h expected %h", {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
      end else passed++;
      checks++;
      if (out_valid !== (t >= 5)) begin
        $display("[TB] FAIL midreset_timing t=%0d: got %b expected %b", t, out_valid, (t >= 5));
      end else passed++;
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 70; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 11);
          if (r < 10) seg[i] = digit_pat[r];
          else if (r == 10) seg[i] = 7'b1111110;
          else seg[i] = 7'($urandom);
        end
      end
      for (int h = $urandom_range(1, 8); h > 0; h--) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        checks++;
        if ({out_valid, bcd, digit_err, fault} !== {m_valid, m_word}) begin
          $display("[TB] FAIL random_model n=%0d: got %h expected %h", n, {out_valid, bcd, digit_err, fault}, {m_valid, m_word});
        end else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flicker();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
